// File: rtl/fifo_rptr_empty_fwft_pkg.sv
// Shared Gray/binary helpers for both FIFO pointer domains.
// Functions work on 32-bit values; callers zero-extend and truncate to pointer width.
package fifo_rptr_empty_fwft_pkg;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bit i of the binary value is the XOR of all Gray bits at or above i
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rptr_empty_fwft_if.sv
// Read-side bundle: synchronized write pointer and memory port in, FWFT output stage out.
// master is the read controller; slave is the memory/consumer environment.
interface fifo_rptr_empty_fwft_if #(
  parameter int ADDRESS    = 3,
  parameter int DATA_WIDTH = 8
);
  logic [ADDRESS:0]      RQ2_WPTR;
  logic [DATA_WIDTH-1:0] R_DATA;
  logic                  DOUT_READY;
  logic [ADDRESS-1:0]    R_ADDR;
  logic [ADDRESS:0]      R_PTR;
  logic                  R_EMPTY;
  logic [ADDRESS:0]      R_LEVEL;
  logic                  R_ALMOST_EMPTY;
  logic [DATA_WIDTH-1:0] DOUT;
  logic                  DOUT_VALID;

  modport master (
    input  RQ2_WPTR, R_DATA, DOUT_READY,
    output R_ADDR, R_PTR, R_EMPTY, R_LEVEL, R_ALMOST_EMPTY, DOUT, DOUT_VALID
  );

  modport slave (
    output RQ2_WPTR, R_DATA, DOUT_READY,
    input  R_ADDR, R_PTR, R_EMPTY, R_LEVEL, R_ALMOST_EMPTY, DOUT, DOUT_VALID
  );
endinterface

// File: rtl/fifo_rptr_empty_fwft_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the read and write pointer stages for their fill levels.
module fifo_gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^(gray_i >> i);
  end

endmodule

// File: rtl/fifo_rptr_empty_fwft.sv
// Async-FIFO read controller: Gray/binary read pointers, registered empty/level, FWFT output register.
// Pop needs no bubble: the output register refills in the same cycle its word is taken.
module fifo_rptr_empty_fwft
  import fifo_rptr_empty_fwft_pkg::*;
#(
  parameter int ADDRESS    = 3,
  parameter int DATA_WIDTH = 8,
  parameter int AE_THRESH  = 1
) (
  input logic                   R_CLK,
  input logic                   R_RST,
  fifo_rptr_empty_fwft_if.master bus
);

  localparam int PTR_W = ADDRESS + 1;
  localparam logic [ADDRESS:0] AE_LIMIT = PTR_W'(AE_THRESH);

  logic [ADDRESS:0]      rbin_q, rbin_d;
  logic [ADDRESS:0]      rgray_q, rgray_d;
  logic                  empty_q, empty_d;
  logic [ADDRESS:0]      level_q, level_d;
  logic                  ae_q, ae_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dvld_q, dvld_d;
  logic [ADDRESS:0]      wbin;
  logic                  pop;

  fifo_gray2bin #(.WIDTH(PTR_W)) u_wptr_g2b (
    .gray_i (bus.RQ2_WPTR),
    .bin_o  (wbin)
  );

  always_comb begin
    pop     = !empty_q && (!dvld_q || bus.DOUT_READY);
    rbin_d  = rbin_q + PTR_W'(pop);
    rgray_d = PTR_W'(bin2gray(32'(rbin_d)));
    // Full Gray equality covers the wrap bit, so empty needs no MSB special case
    empty_d = (rgray_d == bus.RQ2_WPTR);
    level_d = wbin - rbin_d;
    ae_d    = (level_d <= AE_LIMIT);
    dout_d  = dout_q;
    dvld_d  = dvld_q;
    if (pop) begin
      dout_d = bus.R_DATA;
      dvld_d = 1'b1;
    end else if (bus.DOUT_READY) begin
      dvld_d = 1'b0;
    end
  end

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      empty_q <= 1'b1;
      level_q <= '0;
      ae_q    <= 1'b1;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      empty_q <= empty_d;
      level_q <= level_d;
      ae_q    <= ae_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
    end
  end

  assign bus.R_ADDR         = rbin_q[ADDRESS-1:0];
  assign bus.R_PTR          = rgray_q;
  assign bus.R_EMPTY        = empty_q;
  assign bus.R_LEVEL        = level_q;
  assign bus.R_ALMOST_EMPTY = ae_q;
  assign bus.DOUT           = dout_q;
  assign bus.DOUT_VALID     = dvld_q;

endmodule

// File: tb/tb_fifo_rptr_empty_fwft.sv
// Bench for the FIFO read controller: vector table, directed corners, then random traffic vs a count-based model.
module tb_fifo_rptr_empty_fwft;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic [7:0] mem [8];
  logic [7:0] data_log [1024];

  fifo_rptr_empty_fwft_if #(.ADDRESS(3), .DATA_WIDTH(8)) bus ();

  fifo_rptr_empty_fwft #(.ADDRESS(3), .DATA_WIDTH(8), .AE_THRESH(1)) dut (
    .R_CLK (clk),
    .R_RST (rst_n),
    .bus   (bus)
  );

  assign bus.R_DATA = mem[bus.R_ADDR];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] wbin;
    logic       rdy;
    logic       e_empty;
    logic [3:0] e_level;
    logic       e_ae;
    logic       e_vld;
    logic [7:0] e_dout;
    logic [2:0] e_addr;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model state: counts of words written/popped, plus the output register
  int         wr, m_rd, m_level;
  logic       m_empty, m_vld, m_pop;
  logic [7:0] m_dout;
  logic [3:0] prev_ptr;
  logic       prev_pop;

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    bus.RQ2_WPTR = 4'd0;
    bus.DOUT_READY = 1'b0;

    tbl[0]  = '{4'd1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[1]  = '{4'd1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 8'hA5, 3'd1};
    tbl[2]  = '{4'd4, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 8'hA5, 3'd1};
    for (int i = 3; i <= 6; i++) tbl[i] = tbl[2];
    tbl[7]  = '{4'd4, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 8'h11, 3'd2};
    tbl[8]  = '{4'd4, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 8'h22, 3'd3};
    tbl[9]  = '{4'd5, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 8'h33, 3'd4};
    tbl[10] = '{4'd5, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 8'h44, 3'd5};
    tbl[11] = '{4'd5, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 8'h44, 3'd5};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_empty", bus.R_EMPTY, 1);
    chk("reset_level", bus.R_LEVEL, 0);
    chk("reset_ae", bus.R_ALMOST_EMPTY, 1);
    chk("reset_vld", bus.DOUT_VALID, 0);
    chk("reset_ptr", bus.R_PTR, 0);
    chk("reset_dout", bus.DOUT, 0);
    @(negedge clk);

    // Directed vectors: single word, backpressure, simultaneous arrival/pop
    mem[0] = 8'hA5; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33; mem[4] = 8'h44;
    for (int i = 0; i < 12; i++) begin
      bus.RQ2_WPTR   = gray4(int'(tbl[i].wbin));
      bus.DOUT_READY = tbl[i].rdy;
      cycle();
      chk($sformatf("vec%0d_empty", i), bus.R_EMPTY, tbl[i].e_empty);
      chk($sformatf("vec%0d_level", i), bus.R_LEVEL, tbl[i].e_level);
      chk($sformatf("vec%0d_ae", i), bus.R_ALMOST_EMPTY, tbl[i].e_ae);
      chk($sformatf("vec%0d_vld", i), bus.DOUT_VALID, tbl[i].e_vld);
      chk($sformatf("vec%0d_dout", i), bus.DOUT, tbl[i].e_dout);
      chk($sformatf("vec%0d_addr", i), bus.R_ADDR, tbl[i].e_addr);
      chk($sformatf("vec%0d_ptr", i), bus.R_PTR, gray4(int'(tbl[i].e_addr)));
    end

    // Mid-stream asynchronous reset with a word in DOUT and data pending
    mem[5] = 8'h55; mem[6] = 8'h66; mem[7] = 8'h77;
    bus.RQ2_WPTR = gray4(8);
    bus.DOUT_READY = 1'b0;
    cycle();
    cycle();
    chk("pre_rst_vld", bus.DOUT_VALID, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_empty", bus.R_EMPTY, 1);
    chk("arst_vld", bus.DOUT_VALID, 0);
    chk("arst_ptr", bus.R_PTR, 0);
    chk("arst_level", bus.R_LEVEL, 0);
    bus.RQ2_WPTR = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full drain of eight words with the consumer always ready
    for (int i = 0; i < 8; i++) mem[i] = 8'hC0 + 8'(i);
    bus.RQ2_WPTR = 4'b1100;
    bus.DOUT_READY = 1'b1;
    cycle();
    chk("drain_fill_level", bus.R_LEVEL, 8);
    chk("drain_fill_empty", bus.R_EMPTY, 0);
    chk("drain_fill_ae", bus.R_ALMOST_EMPTY, 0);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk($sformatf("drain%0d_dout", k), bus.DOUT, 8'hC0 + 8'(k));
      chk($sformatf("drain%0d_vld", k), bus.DOUT_VALID, 1);
      chk($sformatf("drain%0d_level", k), bus.R_LEVEL, 7 - k);
      chk($sformatf("drain%0d_ae", k), bus.R_ALMOST_EMPTY, (7 - k) <= 1);
      chk($sformatf("drain%0d_empty", k), bus.R_EMPTY, k == 7);
      chk($sformatf("drain%0d_addr", k), bus.R_ADDR, (k + 1) % 8);
    end
    chk("drain_ptr", bus.R_PTR, 4'b1100);
    cycle();
    chk("drain_done_vld", bus.DOUT_VALID, 0);

    // Random traffic against a count-based model, long enough to wrap the pointer
    rst_n = 1'b0;
    bus.RQ2_WPTR = 4'd0;
    bus.DOUT_READY = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr = 0; m_rd = 0; m_level = 0;
    m_empty = 1'b1; m_vld = 1'b0; m_dout = 8'h00;
    prev_ptr = 4'd0;
    for (int c = 0; c < 400; c++) begin
      if ((wr - m_rd) < 8 && $urandom_range(0, 2) != 0 && wr < 1000) begin
        data_log[wr] = 8'($urandom);
        mem[wr % 8] = data_log[wr];
        wr++;
      end
      bus.RQ2_WPTR   = gray4(wr % 16);
      bus.DOUT_READY = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      m_pop = !m_empty && (!m_vld || bus.DOUT_READY);
      if (m_pop) begin
        m_dout = data_log[m_rd];
        m_vld = 1'b1;
        m_rd++;
      end else if (bus.DOUT_READY) begin
        m_vld = 1'b0;
      end
      m_empty = (m_rd == wr);
      m_level = wr - m_rd;
      prev_pop = m_pop;
      @(negedge clk);
      chk("rnd_empty", bus.R_EMPTY, m_empty);
      chk("rnd_level", bus.R_LEVEL, m_level);
      chk("rnd_ae", bus.R_ALMOST_EMPTY, m_level <= 1);
      chk("rnd_vld", bus.DOUT_VALID, m_vld);
      if (m_vld) chk("rnd_dout", bus.DOUT, m_dout);
      chk("rnd_ptr", bus.R_PTR, gray4(m_rd % 16));
      chk("rnd_addr", bus.R_ADDR, m_rd % 8);
      chk("rnd_ptr_1bit", $countones(bus.R_PTR ^ prev_ptr), prev_pop ? 1 : 0);
      prev_ptr = bus.R_PTR;
    end
    chk("rnd_wrapped", m_rd >= 20, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rptr_empty_fwft.md
# fifo_rptr_empty_fwft

Read-domain controller for the asynchronous FIFO. It sits downstream of the write-pointer/full stage and its two-flop pointer synchronizer. It keeps the binary and Gray read pointers and generates a registered empty flag and fill level from the synchronized write pointer. It drains the dual-port memory into a first-word-fall-through output register with a valid/ready handshake.

## Interface
- `ADDRESS`, default 3: memory address width; depth = 2^ADDRESS; pointers are ADDRESS+1 bits.
- `DATA_WIDTH`, default 8: memory word width.
- `AE_THRESH`, default 1: `R_ALMOST_EMPTY` asserts when the level is ≤ this value.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- `R_CLK` input 1: read-domain clock.
- `R_RST` input 1: asynchronous, active-low reset.
- `RQ2_WPTR` input ADDRESS+1: Gray write pointer, already synchronized into `R_CLK`.
- `R_DATA` input DATA_WIDTH: memory read data; asynchronous read at `R_ADDR`.
- `DOUT_READY` input 1: consumer accepts `DOUT` this cycle.
- `R_ADDR` output ADDRESS: memory read address = binary read pointer[ADDRESS-1:0].
- `R_PTR` output ADDRESS+1: registered Gray read pointer, sent to the write-domain synchronizer.
- `R_EMPTY` output 1: registered; memory holds no unread word.
- `R_LEVEL` output ADDRESS+1: registered count of words in memory, 0..2^ADDRESS. Excludes the word held in `DOUT`.
- `R_ALMOST_EMPTY` output 1: registered, `R_LEVEL` ≤ `AE_THRESH`.
- `DOUT` output DATA_WIDTH: output data register.
- `DOUT_VALID` output 1: `DOUT` holds an unconsumed word.

## Operation
- **Pop:** `pop = !R_EMPTY && (!DOUT_VALID || DOUT_READY)`.
- **Next pointer:** `rbin_next = rbin + pop`, mod 2^(ADDRESS+1). `rgray_next = (rbin_next >> 1) ^ rbin_next`.
- **Each cycle:**
  - `rbin <= rbin_next`
  - `R_PTR <= rgray_next`
  - `R_EMPTY <= (rgray_next == RQ2_WPTR)`
- **Level:** `wbin = gray2bin(RQ2_WPTR)`. `R_LEVEL <= wbin - rbin_next`, mod 2^(ADDRESS+1). `R_ALMOST_EMPTY <= (wbin - rbin_next) <= AE_THRESH`.
- **Output stage:**
  - On `pop`: `DOUT <= R_DATA`, `DOUT_VALID <= 1`.
  - Else if `DOUT_READY`: `DOUT_VALID <= 0`; `DOUT` holds its value.
- **Handshake:** a word transfers on `DOUT_VALID && DOUT_READY`. `DOUT` and `DOUT_VALID` must not change while `DOUT_VALID=1` and `DOUT_READY=0`.
- **Pointer wrap:** the pointer MSB toggles every 2^ADDRESS pops. Empty means full Gray equality, so no MSB special case is needed.
- **Simultaneous write arrival and pop:** the level is computed from the same-cycle `rbin_next` and the current `RQ2_WPTR`. The result is always within 0..2^ADDRESS.
- **Reset values:** all pointers 0, `R_PTR`=0, `R_EMPTY`=1, `R_LEVEL`=0, `R_ALMOST_EMPTY`=1, `DOUT`=0, `DOUT_VALID`=0.
- **Reset mid-operation:** asynchronous; returns immediately to reset values, and contents are discarded.

## Timing
- Every output is a flop output except `R_ADDR`, which is driven directly from the `rbin` register.
- **Latency, new write to output:** `RQ2_WPTR` changes at edge N; `R_EMPTY` falls after edge N+1; pop at edge N+2, so `DOUT_VALID`=1 after edge N+2.
- **Back-to-back reads:** with `DOUT_READY` held at 1 and the FIFO non-empty, one word is delivered per cycle.
- **Empty flag:** `R_EMPTY` reflects the post-pop pointer. After the last word is popped it is 1 the next cycle, with no over-read.
- **Pessimism:** `R_EMPTY` and `R_LEVEL` lag real writes by synchronizer latency plus one cycle. They never report data that is not present.

## Structure
- **Shared header `fifo_defs`:** `bin2gray` and `gray2bin` functions, also used by the write-side stage.
- **Sub-module `fifo_gray2bin`:**
  - Parameterized combinational XOR-prefix converter, width ADDRESS+1.
  - Instantiated once, for `RQ2_WPTR`.
  - The write side reuses it for its own level.

## Test plan
ADDRESS=3, DATA_WIDTH=8, AE_THRESH=1.
- **Reset:** assert `R_RST`=0 mid-stream.
  - Outputs immediately go to `R_EMPTY`=1, `DOUT_VALID`=0, `R_PTR`=0, `R_LEVEL`=0.
- **Single word:** drive `RQ2_WPTR` 0→1 with `R_DATA`=0xA5 and `DOUT_READY`=0.
  - `R_EMPTY`=0 and `R_LEVEL`=1 one cycle later.
  - `DOUT`=0xA5 and `DOUT_VALID`=1 two cycles later, then `R_EMPTY`=1 and `R_LEVEL`=0.
- **Backpressure:** with `DOUT_VALID`=1, hold `DOUT_READY`=0 for 5 cycles, with `RQ2_WPTR` at Gray(4) (binary 4).
  - `DOUT` and `DOUT_VALID` stable.
  - `R_ADDR` frozen at 1.
  - `R_LEVEL`=3 throughout.
- **Full drain:** `RQ2_WPTR` = Gray(8) = 4'b1100, `DOUT_READY`=1.
  - Eight consecutive words, addresses 0..7.
  - `R_ALMOST_EMPTY` rises when `R_LEVEL` reaches 1.
  - `R_EMPTY`=1 after the 8th pop; `R_PTR`=4'b1100.
- **Wrap:** run 20 writes and reads.
  - `rbin` wraps 15→0.
  - `R_PTR` sequence is Gray-coded, one bit change per pop.
  - Data order is preserved.
- **Simultaneous events:** advance `RQ2_WPTR` by 1 in the same cycle a pop occurs at level 1.
  - `R_EMPTY` stays 0 and `R_LEVEL` stays 1.
